rle_encoder: RTL and testbench
==============================

# rle_encoder

Run-length encoder that sits directly upstream of the run-length decoding stage. Consumes a byte stream and emits (symbol, run-count) pairs on the same 8-bit data / 4-bit count interface the decoder accepts. Pairs are held in a 2-entry queue, and each pair is released on the decoder's `ready` acknowledge. Runs longer than 15 are split.

## Interface
Parameters:
- `CNT_W`, default 4: run-count width; the maximum run is 2^CNT_W−1 = 15.
- `FIFO_DEPTH`, default 2: depth of the pair queue, in entries.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `data_in`  in  8: input byte.
- `in_valid`  in  1: `data_in` is valid this cycle.
- `in_last`  in  1: qualifies the final byte of a message; valid only with `in_valid`.
- `in_ready`  out  1: the encoder accepts a byte this cycle. A byte transfers when `in_valid & in_ready`.
- `data_dout`  out  8: symbol of the head pair. Connects to the decoder's `data_din`.
- `data_cout`  out  CNT_W: run count of the head pair, range 1..15. Connects to the decoder's `data_cin`.
- `out_valid`  out  1: the head pair is valid.
- `dec_ready`  in  1: decoder `ready`. Its rising edge acknowledges the head pair.

## Operation
- **State:** `sym` (8 bits) and `cnt` (4 bits) hold the run in progress.
- **FSM states:**
  - IDLE: no run open.
  - RUN: run open, `cnt` is 1..15.
  - FLUSH: one pending single-byte run must still be pushed.
- **IDLE, byte accepted:**
  - `sym <= data_in`, `cnt <= 1`, go to RUN.
  - If `in_last` is also set: push (`data_in`, 1) and stay in IDLE.
- **RUN, accepted byte equals `sym` and `cnt < 15`:**
  - Without `in_last`: `cnt <= cnt + 1`.
  - With `in_last`: push (`sym`, `cnt + 1`) and go to IDLE.
- **RUN, accepted byte differs from `sym`, or `cnt == 15`:**
  - Push (`sym`, `cnt`), then load `sym <= data_in`, `cnt <= 1`.
  - Without `in_last`: stay in RUN.
  - With `in_last`: go to FLUSH.
- **FLUSH:**
  - `in_ready = 0`.
  - When the queue is not full, push (`sym`, 1) and go to IDLE.
- **`in_ready`:** equals `(state != FLUSH) & ~fifo_full`. The encoder performs at most one push per cycle.
- **Acknowledge:**
  - `dec_ack = dec_ready & ~dec_ready_q`, where `dec_ready_q` is `dec_ready` registered once.
  - When `dec_ack & out_valid`, pop the head pair.
  - `dec_ack` without `out_valid` is ignored.
  - `dec_ready` held high across several cycles counts as one acknowledge.
- **Simultaneous push and pop:** allowed in the same cycle, including when the queue is full. The occupancy count is unchanged in that case.
- **Queue pointers:** 1-bit, wrap modulo `FIFO_DEPTH`. Occupancy ranges 0..2.
- **Count rules:** a count of 0 is never emitted. Count arithmetic never overflows, because the `cnt == 15` split takes priority over increment.
- **Open run without `in_last`:** a run that is never terminated by `in_last` stays open indefinitely. No timeout.

## Timing
- **Reset values:**
  - `in_ready = 0` while `RST` is asserted.
  - `out_valid = 0`, `data_dout = 0`, `data_cout = 0`.
  - `state = IDLE`, `cnt = 0`, `sym = 0`, queue empty, `dec_ready_q = 0`.
- **First cycle after reset release:** `in_ready = 1`.
- **Reset mid-operation:** the open run and all queued pairs are discarded immediately (asynchronous).
- **Push-to-output latency:** a pair pushed at edge N is visible with `out_valid = 1` after edge N, when the queue was empty.
- **Acknowledge latency:**
  - A `dec_ready` rising at edge M is registered into `dec_ready_q` at edge M.
  - The resulting pop happens at edge M+1.
  - The next pair, if any, is presented after edge M+1.
- **Output stability:** `data_dout` and `data_cout` stay stable while `out_valid = 1` and no pop occurs. All outputs are registered.
- **Throughput:** one input byte per cycle while the queue is not full.

## Structure
- Shared package `rle_pkg`:
  - `SYM_W = 8`, `CNT_W = 4`, `CNT_MAX = 15`.
  - Packed struct `rle_pair_t` with fields `{sym, cnt}`.
  - FSM enum `{IDLE, RUN, FLUSH}`.
- One sub-module, `rle_pair_fifo`: 2-entry synchronous FIFO of `rle_pair_t` with push, pop, full and empty, reset by async `RST`.
- The top level holds the run FSM, the `dec_ready` edge detector and the output mapping.

## Test plan
- **Matches the decoder bench stream:**
  - Stimulus: stream 100,100,97,97,97,98,98,99,99,99,99 with `in_last` on the final byte; the decoder model pulses `ready` 3 cycles after each `out_valid`.
  - Required: pairs (100,2), (97,3), (98,2), (99,4) in order.
- **Run split:** 20 × byte 97, `in_last` on the last byte -> pairs (97,15), (97,5).
- **Terminating byte with `in_last`:**
  - Stimulus: 65,65,66 with `in_last` on 66.
  - Required: (65,2), then FLUSH for one cycle with `in_ready = 0`, then (66,1).
- **Backpressure:**
  - Stimulus: alternating bytes 1,2,3,4,… with `dec_ready` held low.
  - Required: after pairs (1,1) and (2,1) fill the queue, `in_ready = 0`. The first `dec_ready` rising edge pops (1,1), and `in_ready` returns to 1 the cycle after the pop.
- **Held acknowledge:** `dec_ready` high for 5 cycles pops exactly one pair.
- **Mid-run reset:**
  - Stimulus: `RST` pulsed after 7,7,7 with one pair already queued.
  - Required: `out_valid = 0` immediately. A following 9 with `in_last` yields only (9,1).

Source files
------------

// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types and constants for the run-length encoder
package rle_pkg;

    localparam int SYM_W   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } rle_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_t;

endpackage

// File: rtl/rle_pair_fifo.sv
// rtl/rle_pair_fifo.sv - small synchronous queue of (symbol, count) pairs
module rle_pair_fifo
    import rle_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      push,
    input  rle_pair_t push_data,
    input  logic      pop,
    output rle_pair_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    rle_pair_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    // A push into a full queue is fine when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - byte stream to (symbol, run-count) pair encoder
module rle_encoder #(
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       data_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       data_dout,
    output logic [CNT_W-1:0] data_cout,
    output logic             out_valid,
    input  logic             dec_ready
);

    import rle_pkg::*;

    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    rle_state_t       state;
    rle_state_t       state_n;
    logic [7:0]       sym;
    logic [7:0]       sym_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             push;
    rle_pair_t        push_pair;
    rle_pair_t        head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             extend;
    logic             dec_ready_q;
    logic             dec_ack;
    logic             ack_q;
    logic             pop;

    assign in_ready = ~RST & (state != FLUSH) & ~full;
    assign accept   = in_valid & in_ready;
    // The saturation split wins over extending, so cnt never wraps.
    assign extend   = (data_in == sym) && (cnt != RUN_MAX);

    always_comb begin
        state_n   = state;
        sym_n     = sym;
        cnt_n     = cnt;
        push      = 1'b0;
        push_pair = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sym_n = data_in;
                    cnt_n = CNT_W'(1);
                    if (in_last) begin
                        push          = 1'b1;
                        push_pair.sym = data_in;
                        push_pair.cnt = CNT_W'(1);
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (extend) begin
                        cnt_n = cnt + CNT_W'(1);
                        if (in_last) begin
                            push          = 1'b1;
                            push_pair.sym = sym;
                            push_pair.cnt = cnt + CNT_W'(1);
                            state_n       = IDLE;
                        end
                    end else begin
                        push          = 1'b1;
                        push_pair.sym = sym;
                        push_pair.cnt = cnt;
                        sym_n         = data_in;
                        cnt_n         = CNT_W'(1);
                        state_n       = in_last ? FLUSH : RUN;
                    end
                end
            end
            FLUSH: begin
                if (!full) begin
                    push          = 1'b1;
                    push_pair.sym = sym;
                    push_pair.cnt = CNT_W'(1);
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sym   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sym   <= sym_n;
            cnt   <= cnt_n;
        end
    end

    // Rising edge of dec_ready is latched for one cycle before it pops the head.
    assign dec_ack = dec_ready & ~dec_ready_q;
    assign pop     = ack_q & out_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_ready_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            dec_ready_q <= dec_ready;
            ack_q       <= dec_ack;
        end
    end

    rle_pair_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = ~empty;
    assign data_dout = head.sym;
    assign data_cout = head.cnt;

endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - directed self-checking bench for rle_encoder
module tb_rle_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] data_dout;
    logic [3:0] data_cout;
    logic       out_valid;
    logic       dec_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_sym [8];
    logic [3:0] got_cnt [8];

    rle_encoder #(
        .CNT_W      (4),
        .FIFO_DEPTH (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .data_dout (data_dout),
        .data_cout (data_cout),
        .out_valid (out_valid),
        .dec_ready (dec_ready)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok = 0;
        data_in  = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout byte=%0d in_ready=%b required 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_pair(input int idx);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL recv_timeout idx=%0d out_valid=%b required 1", idx, out_valid);
        end
        got_sym[idx] = data_dout;
        got_cnt[idx] = data_cout;
        repeat (3) @(posedge clk);
        #1 dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic recv_n(input int n);
        for (int k = 0; k < n; k++) recv_pair(k);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        if (data_dout !== 8'd0) begin errors++; $display("FAIL reset_dout got %0d required 0", data_dout); end
        if (data_cout !== 4'd0) begin errors++; $display("FAIL reset_cout got %0d required 0", data_cout); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_decoder_stream();
        logic [7:0] stim [11] = '{8'd100, 8'd100, 8'd97, 8'd97, 8'd97, 8'd98, 8'd98,
                                  8'd99, 8'd99, 8'd99, 8'd99};
        logic [7:0] exp_s [4] = '{8'd100, 8'd97, 8'd98, 8'd99};
        logic [3:0] exp_c [4] = '{4'd2, 4'd3, 4'd2, 4'd4};
        fork
            begin
                for (int i = 0; i < 11; i++) send_byte(stim[i], i == 10);
            end
            recv_n(4);
        join
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (got_sym[i] !== exp_s[i]) begin errors++; $display("FAIL stream_sym[%0d] got %0d required %0d", i, got_sym[i], exp_s[i]); end
            if (got_cnt[i] !== exp_c[i]) begin errors++; $display("FAIL stream_cnt[%0d] got %0d required %0d", i, got_cnt[i], exp_c[i]); end
        end
    endtask

    task automatic test_run_split();
        fork
            begin
                for (int i = 0; i < 20; i++) send_byte(8'd97, i == 19);
            end
            recv_n(2);
        join
        checks += 4;
        if (got_sym[0] !== 8'd97) begin errors++; $display("FAIL split_sym0 got %0d required 97", got_sym[0]); end
        if (got_cnt[0] !== 4'd15) begin errors++; $display("FAIL split_cnt0 got %0d required 15", got_cnt[0]); end
        if (got_sym[1] !== 8'd97) begin errors++; $display("FAIL split_sym1 got %0d required 97", got_sym[1]); end
        if (got_cnt[1] !== 4'd5) begin errors++; $display("FAIL split_cnt1 got %0d required 5", got_cnt[1]); end
    endtask

    task automatic test_flush();
        send_byte(8'd65, 1'b0);
        send_byte(8'd65, 1'b0);
        send_byte(8'd66, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b required 0", in_ready); end
        recv_n(2);
        checks += 4;
        if (got_sym[0] !== 8'd65) begin errors++; $display("FAIL flush_sym0 got %0d required 65", got_sym[0]); end
        if (got_cnt[0] !== 4'd2) begin errors++; $display("FAIL flush_cnt0 got %0d required 2", got_cnt[0]); end
        if (got_sym[1] !== 8'd66) begin errors++; $display("FAIL flush_sym1 got %0d required 66", got_sym[1]); end
        if (got_cnt[1] !== 4'd1) begin errors++; $display("FAIL flush_cnt1 got %0d required 1", got_cnt[1]); end
    endtask

    task automatic test_backpressure();
        send_byte(8'd1, 1'b0);
        send_byte(8'd2, 1'b0);
        send_byte(8'd3, 1'b0);
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b required 0", in_ready); end
        if (data_dout !== 8'd1) begin errors++; $display("FAIL bp_head_sym got %0d required 1", data_dout); end
        if (data_cout !== 4'd1) begin errors++; $display("FAIL bp_head_cnt got %0d required 1", data_cout); end
        @(posedge clk);
        #1 dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_before_pop_in_ready got %b required 0", in_ready); end
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_in_ready got %b required 1", in_ready); end
        if (data_dout !== 8'd2) begin errors++; $display("FAIL bp_next_head got %0d required 2", data_dout); end
        @(posedge clk);
        #1;
        fork
            send_byte(8'd4, 1'b1);
            recv_n(3);
        join
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (got_sym[i] !== 8'(i + 2)) begin errors++; $display("FAIL bp_sym[%0d] got %0d required %0d", i, got_sym[i], i + 2); end
            if (got_cnt[i] !== 4'd1) begin errors++; $display("FAIL bp_cnt[%0d] got %0d required 1", i, got_cnt[i]); end
        end
    endtask

    task automatic test_held_ack();
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b1);
        @(posedge clk);
        #1 dec_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL held_out_valid got %b required 1", out_valid); end
        if (data_dout !== 8'd6) begin errors++; $display("FAIL held_head_sym got %0d required 6", data_dout); end
        if (data_cout !== 4'd1) begin errors++; $display("FAIL held_head_cnt got %0d required 1", data_cout); end
        recv_n(1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL held_drained got %b required 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        send_byte(8'd5, 1'b0);
        send_byte(8'd7, 1'b0);
        send_byte(8'd7, 1'b0);
        send_byte(8'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || data_dout !== 8'd5) begin
            errors++;
            $display("FAIL mid_pre_reset got valid=%b sym=%0d required valid=1 sym=5", out_valid, data_dout);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got %b required 0", in_ready); end
        #1 rst = 1'b0;
        send_byte(8'd9, 1'b1);
        recv_n(1);
        checks += 2;
        if (got_sym[0] !== 8'd9) begin errors++; $display("FAIL mid_sym got %0d required 9", got_sym[0]); end
        if (got_cnt[0] !== 4'd1) begin errors++; $display("FAIL mid_cnt got %0d required 1", got_cnt[0]); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_extra_pair got %b required 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_decoder_stream();
        test_run_split();
        test_flush();
        test_backpressure();
        test_held_ack();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
